// File: rtl/riscv_pkg.sv
// RV32I pipeline shared types: ALU interface and EX-stage micro-op / result records.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLT  = 4'd3,
        BR_BGE  = 4'd4,
        BR_BLTU = 4'd5,
        BR_BGEU = 4'd6,
        BR_JAL  = 4'd7,
        BR_JALR = 4'd8
    } br_type_e;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic {
        B_RS2 = 1'b0,
        B_IMM = 1'b1
    } b_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        alu_op_e         op;
    } alu_in_t;

    typedef struct packed {
        logic [XLEN-1:0] y;
        logic            zero;
        logic            lt_signed;
        logic            lt_unsigned;
    } alu_out_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        alu_op_e         alu_op;
        a_sel_e          a_sel;
        b_sel_e          b_sel;
        br_type_e        br_type;
        logic [4:0]      rd;
        logic            we;
    } ex_uop_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            we;
        logic [XLEN-1:0] pc;
        logic            exc_misalign;
    } ex_mem_t;

endpackage

// File: rtl/ex_branch_cond.sv
// Branch/jump taken decision from the ALU compare flags (ALU runs SUB rs1-rs2 for branches).
module ex_branch_cond
    import riscv_pkg::*;
(
    input  br_type_e br_type,
    input  logic     zero,
    input  logic     lt_signed,
    input  logic     lt_unsigned,
    output logic     taken
);

    // Map each control-transfer type onto the matching flag.
    always_comb begin
        taken = 1'b0;
        unique case (br_type)
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = !zero;
            BR_BLT:  taken = lt_signed;
            BR_BGE:  taken = !lt_signed;
            BR_BLTU: taken = lt_unsigned;
            BR_BGEU: taken = !lt_unsigned;
            BR_JAL:  taken = 1'b1;
            BR_JALR: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: holds one micro-op, drives the ALU, resolves control transfers,
// and hands results to MEM over valid/ready. Static not-taken prediction.
module ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    output logic             id_ready_o,
    input  ex_uop_t          id_uop_i,
    output alu_in_t          alu_req_o,
    input  alu_out_t         alu_rsp_i,
    output logic             mem_valid_o,
    input  logic             mem_ready_i,
    output ex_mem_t          mem_o,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    input  logic             flush_i,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] br_taken_o
);

    ex_uop_t          ex_q;
    logic             ex_valid_q;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] br_taken_q;

    logic            accept;
    logic            fire;
    logic            cond_taken;
    logic            taken;
    logic            is_jump;
    logic            misalign;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] link_pc;
    logic [XLEN-1:0] tgt;

    assign id_ready_o  = !ex_valid_q | mem_ready_i;
    assign accept      = id_valid_i & id_ready_o;
    assign fire        = ex_valid_q & mem_ready_i & !flush_i;
    assign mem_valid_o = ex_valid_q & !flush_i;

    // Operand selection toward the ALU; idle stage presents all-zero request.
    always_comb begin
        alu_req_o = '0;
        if (ex_valid_q) begin
            unique case (ex_q.a_sel)
                A_RS1:   alu_req_o.a = ex_q.rs1;
                A_PC:    alu_req_o.a = ex_q.pc;
                default: alu_req_o.a = '0;
            endcase
            alu_req_o.b  = (ex_q.b_sel == B_IMM) ? ex_q.imm : ex_q.rs2;
            alu_req_o.op = ex_q.alu_op;
        end
    end

    ex_branch_cond u_branch_cond (
        .br_type     (ex_q.br_type),
        .zero        (alu_rsp_i.zero),
        .lt_signed   (alu_rsp_i.lt_signed),
        .lt_unsigned (alu_rsp_i.lt_unsigned),
        .taken       (cond_taken)
    );

    assign taken    = ex_valid_q & cond_taken;
    assign is_jump  = (ex_q.br_type == BR_JAL) || (ex_q.br_type == BR_JALR);
    assign br_tgt   = ex_q.pc + ex_q.imm;
    assign link_pc  = ex_q.pc + XLEN'(4);

    // Control-transfer target: branches use the dedicated adder, jumps use ALU y.
    always_comb begin
        tgt = br_tgt;
        unique case (ex_q.br_type)
            BR_JAL:  tgt = alu_rsp_i.y;
            BR_JALR: tgt = alu_rsp_i.y & ~XLEN'(1);
            default: tgt = br_tgt;
        endcase
    end

    assign misalign      = taken & ALIGN_CHECK & (tgt[1:0] != 2'b00);
    assign redirect_o    = fire & taken & !misalign;
    assign redirect_pc_o = redirect_o ? tgt : '0;

    // Result record toward MEM; a misaligned jump must not write its link register.
    always_comb begin
        mem_o = '0;
        if (ex_valid_q) begin
            mem_o.result       = is_jump ? link_pc : alu_rsp_i.y;
            mem_o.rd           = ex_q.rd;
            mem_o.we           = ex_q.we & !misalign;
            mem_o.pc           = ex_q.pc;
            mem_o.exc_misalign = misalign;
        end
    end

    // Stage register: a redirect or flush kills anything accepted in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else if (flush_i || redirect_o) begin
            ex_valid_q <= 1'b0;
        end else if (accept) begin
            ex_q       <= id_uop_i;
            ex_valid_q <= 1'b1;
        end else if (fire) begin
            ex_valid_q <= 1'b0;
        end
    end

    // Retired control-transfer statistics, counted once on the leaving cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_cnt_q   <= '0;
            br_taken_q <= '0;
        end else if (fire && (ex_q.br_type != BR_NONE)) begin
            br_cnt_q <= br_cnt_q + CNT_W'(1);
            if (taken) begin
                br_taken_q <= br_taken_q + CNT_W'(1);
            end
        end
    end

    assign br_cnt_o   = br_cnt_q;
    assign br_taken_o = br_taken_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage with a behavioural ALU closing the loop.
module tb_ex_stage;
    import riscv_pkg::*;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] pc;
        logic        mis;
        logic        redir;
        logic [31:0] rpc;
        logic        is_br;
        logic        taken;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    ex_uop_t     id_uop;
    alu_in_t     alu_req;
    alu_out_t    alu_rsp;
    logic        mem_valid;
    logic        mem_ready;
    ex_mem_t     mem_out;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] br_cnt;
    logic [31:0] br_taken;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;
    int   exp_tk   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    ex_stage #(.CNT_W(32), .ALIGN_CHECK(1'b1)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_valid_i    (id_valid),
        .id_ready_o    (id_ready),
        .id_uop_i      (id_uop),
        .alu_req_o     (alu_req),
        .alu_rsp_i     (alu_rsp),
        .mem_valid_o   (mem_valid),
        .mem_ready_i   (mem_ready),
        .mem_o         (mem_out),
        .redirect_o    (redirect),
        .redirect_pc_o (redirect_pc),
        .flush_i       (flush),
        .br_cnt_o      (br_cnt),
        .br_taken_o    (br_taken)
    );

    // Behavioural ALU sitting beside the stage, as in the core top.
    always_comb begin
        alu_rsp = '0;
        case (alu_req.op)
            ALU_SUB: alu_rsp.y = alu_req.a - alu_req.b;
            ALU_AND: alu_rsp.y = alu_req.a & alu_req.b;
            ALU_OR:  alu_rsp.y = alu_req.a | alu_req.b;
            ALU_XOR: alu_rsp.y = alu_req.a ^ alu_req.b;
            default: alu_rsp.y = alu_req.a + alu_req.b;
        endcase
        alu_rsp.zero        = (alu_rsp.y == '0);
        alu_rsp.lt_signed   = $signed(alu_req.a) < $signed(alu_req.b);
        alu_rsp.lt_unsigned = alu_req.a < alu_req.b;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ex_uop_t mk(input logic [31:0] pc, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input logic [31:0] imm,
                                   input alu_op_e op, input a_sel_e as, input b_sel_e bs,
                                   input br_type_e br, input logic [4:0] rd, input logic we);
        ex_uop_t u;
        u.pc = pc; u.rs1 = rs1; u.rs2 = rs2; u.imm = imm; u.alu_op = op;
        u.a_sel = as; u.b_sel = bs; u.br_type = br; u.rd = rd; u.we = we;
        return u;
    endfunction

    // Architectural expectation computed from register values, not ALU flags.
    function automatic exp_t model(input ex_uop_t u);
        exp_t        e;
        logic [31:0] a, b, y, tgt;
        logic        tk, jmp;
        a = (u.a_sel == A_RS1) ? u.rs1 : (u.a_sel == A_PC) ? u.pc : 32'd0;
        b = (u.b_sel == B_IMM) ? u.imm : u.rs2;
        y = (u.alu_op == ALU_SUB) ? a - b : a + b;
        case (u.br_type)
            BR_BEQ:  tk = (u.rs1 == u.rs2);
            BR_BNE:  tk = (u.rs1 != u.rs2);
            BR_BLT:  tk = ($signed(u.rs1) < $signed(u.rs2));
            BR_BGE:  tk = !($signed(u.rs1) < $signed(u.rs2));
            BR_BLTU: tk = (u.rs1 < u.rs2);
            BR_BGEU: tk = !(u.rs1 < u.rs2);
            BR_JAL, BR_JALR: tk = 1'b1;
            default: tk = 1'b0;
        endcase
        jmp = (u.br_type == BR_JAL) || (u.br_type == BR_JALR);
        if (u.br_type == BR_JAL)       tgt = u.pc + u.imm;
        else if (u.br_type == BR_JALR) tgt = (u.rs1 + u.imm) & 32'hFFFF_FFFE;
        else                           tgt = u.pc + u.imm;
        e.mis    = tk && (tgt[1:0] != 2'b00);
        e.result = jmp ? u.pc + 32'd4 : y;
        e.rd     = u.rd;
        e.we     = u.we && !e.mis;
        e.pc     = u.pc;
        e.redir  = tk && !e.mis;
        e.rpc    = e.redir ? tgt : 32'd0;
        e.is_br  = (u.br_type != BR_NONE);
        e.taken  = tk;
        return e;
    endfunction

    // Output monitor: every MEM handshake consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_valid && mem_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_mem_valid", 32'(mem_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("result", mem_out.result, e.result);
                    check_eq("rd", 32'(mem_out.rd), 32'(e.rd));
                    check_eq("we", 32'(mem_out.we), 32'(e.we));
                    check_eq("pc", mem_out.pc, e.pc);
                    check_eq("exc_misalign", 32'(mem_out.exc_misalign), 32'(e.mis));
                    check_eq("redirect", 32'(redirect), 32'(e.redir));
                    check_eq("redirect_pc", redirect_pc, e.rpc);
                    if (e.is_br) begin
                        exp_cnt++;
                        if (e.taken) exp_tk++;
                    end
                end
            end else begin
                check_eq("idle_redirect", 32'(redirect), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input ex_uop_t u, input bit expect_out);
        int w;
        id_uop   = u;
        id_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!id_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!id_ready) check_eq("id_ready_timeout", 32'(id_ready), 32'd1);
        step();
        id_valid = 1'b0;
        if (expect_out) sb.push_back(model(u));
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_br_cnt"}, br_cnt, 32'(exp_cnt));
        check_eq({tag, "_br_taken"}, br_taken, 32'(exp_tk));
    endtask

    initial begin
        ex_mem_t snap;
        logic [31:0] c0, t0;
        int w;

        rst = 1'b1; id_valid = 1'b0; id_uop = '0; mem_ready = 1'b1; flush = 1'b0;
        repeat (2) step();
        check_eq("rst_mem_valid", 32'(mem_valid), 32'd0);
        check_eq("rst_redirect", 32'(redirect), 32'd0);
        check_eq("rst_redirect_pc", redirect_pc, 32'd0);
        check_eq("rst_mem_o_result", mem_out.result, 32'd0);
        check_eq("rst_alu_req_a", alu_req.a, 32'd0);
        check_eq("rst_br_cnt", br_cnt, 32'd0);
        check_eq("rst_id_ready", 32'(id_ready), 32'd1);
        rst = 1'b0;
        step();

        // ADD then back-to-back PC+IMM and ZERO+IMM forms
        send(mk(32'h40, 32'd5, 32'd7, 32'd0, ALU_ADD, A_RS1, B_RS2, BR_NONE, 5'd3, 1'b1), 1'b1);
        check_eq("add_latency", 32'(mem_valid), 32'd1);
        check_eq("add_no_redirect", 32'(redirect), 32'd0);
        send(mk(32'h44, 32'd0, 32'd0, 32'h10, ALU_ADD, A_PC, B_IMM, BR_NONE, 5'd4, 1'b1), 1'b1);
        send(mk(32'h48, 32'd9, 32'd0, 32'h1234_5000, ALU_ADD, A_ZERO, B_IMM, BR_NONE, 5'd5, 1'b1), 1'b1);
        step();

        // BEQ taken, then not taken
        send(mk(32'h100, 32'd3, 32'd3, 32'h20, ALU_SUB, A_RS1, B_RS2, BR_BEQ, 5'd0, 1'b0), 1'b1);
        check_eq("beq_redirect", 32'(redirect), 32'd1);
        check_eq("beq_redirect_pc", redirect_pc, 32'h120);
        step();
        check_eq("beq_br_taken", br_taken, 32'd1);
        send(mk(32'h100, 32'd3, 32'd4, 32'h20, ALU_SUB, A_RS1, B_RS2, BR_BEQ, 5'd0, 1'b0), 1'b1);
        step();
        check_eq("beq_nt_br_cnt", br_cnt, 32'd2);
        check_eq("beq_nt_br_taken", br_taken, 32'd1);

        // Signed/unsigned compares and wrapping branch target
        send(mk(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8, ALU_SUB, A_RS1, B_RS2, BR_BLT, 5'd0, 1'b0), 1'b1);
        step();
        send(mk(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8, ALU_SUB, A_RS1, B_RS2, BR_BLTU, 5'd0, 1'b0), 1'b1);
        send(mk(32'h204, 32'd2, 32'd2, 32'h8, ALU_SUB, A_RS1, B_RS2, BR_BGEU, 5'd0, 1'b0), 1'b1);
        step();
        send(mk(32'hFFFF_FFFC, 32'd7, 32'd7, 32'd8, ALU_SUB, A_RS1, B_RS2, BR_BEQ, 5'd0, 1'b0), 1'b1);
        check_eq("wrap_redirect_pc", redirect_pc, 32'h4);
        step();
        check_counters("branches");

        // JALR misaligned, JALR aligned, JAL backward
        send(mk(32'h300, 32'h203, 32'd0, 32'd0, ALU_ADD, A_RS1, B_IMM, BR_JALR, 5'd1, 1'b1), 1'b1);
        check_eq("jalr_mis_redirect", 32'(redirect), 32'd0);
        check_eq("jalr_mis_exc", 32'(mem_out.exc_misalign), 32'd1);
        step();
        send(mk(32'h300, 32'h201, 32'd0, 32'd0, ALU_ADD, A_RS1, B_IMM, BR_JALR, 5'd1, 1'b1), 1'b1);
        check_eq("jalr_redirect_pc", redirect_pc, 32'h200);
        check_eq("jalr_link", mem_out.result, 32'h304);
        step();
        send(mk(32'h400, 32'd0, 32'd0, 32'hFFFF_FFF8, ALU_ADD, A_PC, B_IMM, BR_JAL, 5'd1, 1'b1), 1'b1);
        step();
        check_counters("jumps");

        // Backpressure with taken BLTU pending
        mem_ready = 1'b0;
        send(mk(32'h500, 32'd1, 32'd2, 32'h10, ALU_SUB, A_RS1, B_RS2, BR_BLTU, 5'd0, 1'b0), 1'b1);
        snap = mem_out;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_mem_valid", 32'(mem_valid), 32'd1);
            check_eq("bp_id_ready", 32'(id_ready), 32'd0);
            check_eq("bp_stable_result", mem_out.result, snap.result);
            check_eq("bp_stable_pc", mem_out.pc, snap.pc);
            check_eq("bp_no_redirect", 32'(redirect), 32'd0);
            step();
        end
        mem_ready = 1'b1;
        #1;
        check_eq("bp_release_redirect", 32'(redirect), 32'd1);
        check_eq("bp_release_pc", redirect_pc, 32'h510);
        step();

        // Taken branch leaving while ID offers a wrong-path uop
        send(mk(32'h600, 32'd5, 32'd5, 32'h40, ALU_SUB, A_RS1, B_RS2, BR_BEQ, 5'd0, 1'b0), 1'b1);
        id_uop   = mk(32'h604, 32'd1, 32'd1, 32'd0, ALU_ADD, A_RS1, B_RS2, BR_NONE, 5'd6, 1'b1);
        id_valid = 1'b1;
        step();
        id_valid = 1'b0;
        check_eq("wrong_path_dropped", 32'(mem_valid), 32'd0);
        step();
        check_counters("drop");

        // Flush with valid taken BNE, plus a same-cycle accept that must be discarded
        send(mk(32'h700, 32'd1, 32'd2, 32'h40, ALU_SUB, A_RS1, B_RS2, BR_BNE, 5'd0, 1'b0), 1'b0);
        c0 = br_cnt; t0 = br_taken;
        flush    = 1'b1;
        id_uop   = mk(32'h704, 32'd1, 32'd1, 32'd0, ALU_ADD, A_RS1, B_RS2, BR_NONE, 5'd7, 1'b1);
        id_valid = 1'b1;
        #1;
        check_eq("flush_mem_valid", 32'(mem_valid), 32'd0);
        check_eq("flush_redirect", 32'(redirect), 32'd0);
        step();
        flush = 1'b0; id_valid = 1'b0; mem_ready = 1'b0;
        #1;
        check_eq("flush_ex_empty", 32'(id_ready), 32'd1);
        check_eq("flush_mem_valid_after", 32'(mem_valid), 32'd0);
        check_eq("flush_br_cnt", br_cnt, c0);
        check_eq("flush_br_taken", br_taken, t0);

        // Reset while a result is stalled
        send(mk(32'h800, 32'd1, 32'd2, 32'h10, ALU_SUB, A_RS1, B_RS2, BR_BNE, 5'd0, 1'b0), 1'b0);
        rst = 1'b1;
        step();
        check_eq("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
        check_eq("mid_rst_br_cnt", br_cnt, 32'd0);
        rst = 1'b0; mem_ready = 1'b1; exp_cnt = 0; exp_tk = 0;
        step();
        check_eq("post_rst_redirect", 32'(redirect), 32'd0);
        send(mk(32'h900, 32'd8, 32'd3, 32'd0, ALU_SUB, A_RS1, B_RS2, BR_NONE, 5'd9, 1'b1), 1'b1);

        w = 0;
        while (sb.size() != 0 && w < 20) begin
            step();
            w++;
        end
        check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
